// File: rtl/clk_pm_pkg.sv
// Shared types and constants for the clock power-mode controller.
package clk_pm_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SLOW      = 3'd3,
    ST_GATED     = 3'd4,
    ST_WAKE      = 3'd5
  } pm_state_e;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_GATE = 2'd2,
    MODE_RSVD = 2'd3
  } pm_mode_e;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_WAKECNT = 4'h8;

  localparam int unsigned WAKE_W = 16;

  // The reserved encoding is stored as written but behaves like RUN.
  function automatic pm_mode_e eff_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_SLOW;
      2'd2:    return MODE_GATE;
      default: return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clk_pm_if.sv
// APB slave bus bundle for the clock power-mode controller.
interface clk_pm_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/clk_pm_apb_regs.sv
// CTRL / STATUS / WAKECNT register block with zero-wait-state combinational read.
module clk_pm_apb_regs
  import clk_pm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  clk_pm_if.slave    apb,
  input  pm_state_e  state,
  input  logic       pm_busy,
  input  logic       cpu_idle,
  input  logic       mode_clr,
  input  logic       wake_inc,
  output logic [1:0] mode
);

  logic [WAKE_W-1:0] wake_cnt;
  logic              wr;
  logic              rd;
  logic              unused_wdata;

  assign wr           = apb.psel && apb.penable && apb.pwrite;
  assign rd           = apb.psel && apb.penable && !apb.pwrite;
  assign unused_wdata = ^apb.pwdata[31:2];

  // Hardware wake events take priority over a same-edge software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= '0;
      wake_cnt <= '0;
    end else begin
      if (mode_clr)
        mode <= MODE_RUN;
      else if (wr && apb.paddr == ADDR_CTRL)
        mode <= apb.pwdata[1:0];

      if (wake_inc) begin
        if (wake_cnt != '1)
          wake_cnt <= wake_cnt + 1'b1;
      end else if (wr && apb.paddr == ADDR_WAKECNT) begin
        wake_cnt <= '0;
      end
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (rd) begin
      case (apb.paddr)
        ADDR_CTRL:    apb.prdata = {30'b0, mode};
        ADDR_STATUS:  apb.prdata = {27'b0, cpu_idle, pm_busy, state};
        ADDR_WAKECNT: apb.prdata = {{(32 - WAKE_W){1'b0}}, wake_cnt};
        default:      apb.prdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/clk_pm_ctrl.sv
// Clock power-mode controller: sequences RUN/SLOW/GATE transitions with idle
// handshake and settle delays, driving the clock generator gate enables.
module clk_pm_ctrl
  import clk_pm_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic    i_pad_clk,
  input  logic    clkrst_b,
  clk_pm_if.slave apb,
  input  logic    cpu_idle,
  input  logic    wake_req,
  output logic    gate_en0,
  output logic    gate_en1,
  output logic    pm_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  pm_state_e        state;
  pm_mode_e         tgt;
  pm_mode_e         cur_mode;
  logic [1:0]       mode;
  logic [CNT_W-1:0] cnt;
  logic             wake_take;

  assign cur_mode  = eff_mode(mode);
  assign wake_take = wake_req && (state == ST_SLOW || state == ST_GATED);
  assign pm_busy   = (state != ST_RUN);

  clk_pm_apb_regs u_regs (
    .clk      (i_pad_clk),
    .rst_n    (clkrst_b),
    .apb      (apb),
    .state    (state),
    .pm_busy  (pm_busy),
    .cpu_idle (cpu_idle),
    .mode_clr (wake_take),
    .wake_inc (wake_take),
    .mode     (mode)
  );

  // Gate enables are assigned alongside each state change so they track next-state.
  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state    <= ST_RUN;
      tgt      <= MODE_RUN;
      cnt      <= '0;
      gate_en0 <= 1'b0;
      gate_en1 <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cur_mode != MODE_RUN)
            state <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (cur_mode == MODE_RUN) begin
            state <= ST_RUN;
          end else if (cpu_idle) begin
            state <= ST_SETTLE;
            tgt   <= cur_mode;
            cnt   <= CNT_LOAD;
          end
        end
        ST_SETTLE: begin
          if (!cpu_idle) begin
            state <= ST_WAIT_IDLE;
          end else if (cur_mode == MODE_RUN) begin
            state <= ST_RUN;
          end else if (cnt == '0) begin
            state    <= (tgt == MODE_SLOW) ? ST_SLOW : ST_GATED;
            gate_en0 <= (tgt == MODE_SLOW);
            gate_en1 <= (tgt != MODE_SLOW);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SLOW, ST_GATED: begin
          if (wake_req || cur_mode != tgt) begin
            state    <= ST_WAKE;
            cnt      <= CNT_LOAD;
            gate_en0 <= 1'b0;
            gate_en1 <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (cnt == '0)
            state <= ST_RUN;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          gate_en0 <= 1'b0;
          gate_en1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_pm_ctrl.sv
// Self-checking bench for clk_pm_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the power-mode rules.
module tb_clk_pm_ctrl;

  localparam int ST = 16;

  logic clk;
  logic rst_n;
  logic cpu_idle;
  logic wake_req;
  logic gate_en0;
  logic gate_en1;
  logic pm_busy;

  clk_pm_if apb_if ();

  clk_pm_ctrl #(.SETTLE_CYC(ST), .CNT_W(8)) dut (
    .i_pad_clk (clk),
    .clkrst_b  (rst_n),
    .apb       (apb_if),
    .cpu_idle  (cpu_idle),
    .wake_req  (wake_req),
    .gate_en0  (gate_en0),
    .gate_en1  (gate_en1),
    .pm_busy   (pm_busy)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase code per the mode rules, age = cycles spent in phase.
  int         ms    = 0;
  int         mage  = 0;
  int         mtgt  = 0;
  logic [1:0] mmode = '0;
  logic [15:0] mw   = '0;

  function automatic int effm(input logic [1:0] m);
    return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
  endfunction

  task automatic model_step();
    int nxt;
    int eff;
    bit hw_wake;
    bit wr_ctrl;
    bit wr_wk;
    nxt     = ms;
    hw_wake = 1'b0;
    eff     = effm(mmode);
    wr_ctrl = apb_if.psel && apb_if.penable && apb_if.pwrite && apb_if.paddr == 4'h0;
    wr_wk   = apb_if.psel && apb_if.penable && apb_if.pwrite && apb_if.paddr == 4'h8;
    case (ms)
      0: if (eff != 0) nxt = 1;
      1: begin
        if (eff == 0) nxt = 0;
        else if (cpu_idle) begin nxt = 2; mtgt = eff; end
      end
      2: begin
        if (!cpu_idle) nxt = 1;
        else if (eff == 0) nxt = 0;
        else if (mage == ST - 1) nxt = (mtgt == 1) ? 3 : 4;
      end
      3, 4: begin
        if (wake_req) begin nxt = 5; hw_wake = 1'b1; end
        else if (eff != mtgt) nxt = 5;
      end
      5: if (mage == ST - 1) nxt = 0;
      default: nxt = 0;
    endcase
    mage = (nxt == ms) ? mage + 1 : 0;
    if (hw_wake) mmode = 2'd0;
    else if (wr_ctrl) mmode = apb_if.pwdata[1:0];
    if (hw_wake) begin
      if (mw != 16'hFFFF) mw = mw + 16'd1;
    end else if (wr_wk) begin
      mw = '0;
    end
    ms = nxt;
  endtask

  function automatic logic [31:0] model_read();
    logic [2:0] code;
    code = 3'(ms);
    if (!(apb_if.psel && apb_if.penable && !apb_if.pwrite)) return '0;
    case (apb_if.paddr)
      4'h0:    return {30'b0, mmode};
      4'h4:    return {27'b0, cpu_idle, (ms != 0), code};
      4'h8:    return {16'b0, mw};
      default: return '0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ms = 0; mage = 0; mtgt = 0; mmode = '0; mw = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("gate_en0", {31'b0, gate_en0}, {31'b0, (ms == 3)});
      check("gate_en1", {31'b0, gate_en1}, {31'b0, (ms == 4)});
      check("pm_busy",  {31'b0, pm_busy},  {31'b0, (ms != 0)});
      check("prdata",   apb_if.prdata, model_read());
    end
  end

  task automatic apb_idle();
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #2;
    apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
    apb_if.paddr = a; apb_if.pwdata = d;
    @(posedge clk); #2;
    apb_idle();
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk); #2;
    apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b0; apb_if.paddr = a;
    #1 d = apb_if.prdata;
    #1 apb_idle();
  endtask

  // sel: 0 gate_en0 high, 1 gate_en1 high, 2 pm_busy low, 3 pm_busy high
  task automatic wait_for(input int sel, input int budget, input string name, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = gate_en0;
        1: hit = gate_en1;
        2: hit = !pm_busy;
        default: hit = pm_busy;
      endcase
    end
    if (!hit) check({name, "_timeout"}, 32'(n), 32'(budget + 1));
  endtask

  logic [31:0] rd;
  int          n;
  int          r;

  initial begin
    rst_n = 1'b0; cpu_idle = 1'b0; wake_req = 1'b0;
    apb_idle();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gate_en0", {31'b0, gate_en0}, 32'd0);
    check("rst_gate_en1", {31'b0, gate_en1}, 32'd0);
    check("rst_pm_busy",  {31'b0, pm_busy},  32'd0);
    apb_read(4'h4, rd); check("rst_status", rd, 32'h0);
    apb_read(4'hC, rd); check("rst_unmapped", rd, 32'h0);
    apb_read(4'h8, rd); check("rst_wakecnt", rd, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // SLOW entry timing and wake_req exit
    cpu_idle = 1'b1;
    apb_write(4'h0, 32'h1);
    wait_for(3, 10, "slow_busy", n);
    wait_for(0, 40, "slow_gate", n);
    check("slow_delay", 32'(n), 32'(ST + 1));
    #2 wake_req = 1'b1;
    @(negedge clk);
    check("wake_gate_en0", {31'b0, gate_en0}, 32'd0);
    #2 wake_req = 1'b0;
    wait_for(2, 40, "wake_run", n);
    check("wake_delay", 32'(n), 32'(ST));
    apb_read(4'h0, rd); check("wake_ctrl", rd, 32'h0);
    apb_read(4'h8, rd); check("wake_cnt1", rd, 32'h1);

    // GATE abort mid-settle, then full delay after re-idle
    apb_write(4'h0, 32'h2);
    wait_for(3, 10, "gate_busy", n);
    repeat (5) @(negedge clk);
    #2 cpu_idle = 1'b0;
    @(negedge clk);
    apb_read(4'h4, rd); check("abort_status", rd, 32'h9);
    check("abort_gate_en1", {31'b0, gate_en1}, 32'd0);
    repeat (3) @(negedge clk);
    #2 cpu_idle = 1'b1;
    wait_for(1, 40, "gate_gate", n);
    check("gate_delay", 32'(n), 32'(ST + 1));

    // Collision: wake_req with a CTRL write while SLOW
    apb_write(4'h0, 32'h1);
    wait_for(0, 100, "coll_slow", n);
    #2;
    wake_req = 1'b1;
    apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
    apb_if.paddr = 4'h0; apb_if.pwdata = 32'h2;
    @(posedge clk); #2;
    apb_idle(); wake_req = 1'b0;
    @(negedge clk);
    check("coll_gate_en0", {31'b0, gate_en0}, 32'd0);
    check("coll_gate_en1", {31'b0, gate_en1}, 32'd0);
    apb_read(4'h0, rd); check("coll_ctrl", rd, 32'h0);
    apb_read(4'h8, rd); check("coll_wakecnt", rd, 32'h2);
    wait_for(2, 40, "coll_run", n);

    // Saturation and clear
    @(negedge clk); #2;
    force dut.u_regs.wake_cnt = 16'hFFFF;
    #1 release dut.u_regs.wake_cnt;
    mw = 16'hFFFF;
    apb_read(4'h8, rd); check("sat_preload", rd, 32'hFFFF);
    apb_write(4'h0, 32'h1);
    wait_for(0, 100, "sat_slow", n);
    #2 wake_req = 1'b1;
    @(negedge clk); #2 wake_req = 1'b0;
    apb_read(4'h8, rd); check("sat_hold", rd, 32'hFFFF);
    wait_for(2, 40, "sat_run", n);
    apb_write(4'h8, 32'h1234);
    apb_read(4'h8, rd); check("wakecnt_clear", rd, 32'h0);
    apb_write(4'hC, 32'h2);
    apb_read(4'h0, rd); check("unmapped_wr", rd, 32'h0);
    apb_write(4'h0, 32'h3);
    apb_read(4'h0, rd); check("ctrl_rsvd", rd, 32'h3);
    repeat (3) @(negedge clk);
    check("rsvd_is_run", {31'b0, pm_busy}, 32'd0);
    apb_write(4'h0, 32'h0);

    // Asynchronous reset while GATED
    apb_write(4'h0, 32'h2);
    wait_for(1, 100, "ar_gated", n);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("ar_gate_en1", {31'b0, gate_en1}, 32'd0);
    check("ar_pm_busy",  {31'b0, pm_busy},  32'd0);
    apb_read(4'h4, rd); check("ar_status", rd, 32'h10);
    apb_read(4'h0, rd); check("ar_ctrl", rd, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #2;
      apb_idle();
      if ($urandom_range(0, 99) < 3) cpu_idle = !cpu_idle;
      wake_req = ($urandom_range(0, 99) < 2);
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
        apb_if.paddr = 4'h0;
        apb_if.pwdata = {$urandom_range(0, 32'h3FFFFFFF), 2'($urandom_range(0, 3))};
      end else if (r < 7) begin
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
        apb_if.paddr = 4'h8; apb_if.pwdata = $urandom;
      end else if (r < 8) begin
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
        apb_if.paddr = 4'($urandom_range(1, 15)); apb_if.pwdata = $urandom;
        if (apb_if.paddr == 4'h8) apb_if.paddr = 4'h4;
      end else if (r < 30) begin
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b0;
        apb_if.paddr = 4'($urandom_range(0, 15));
      end else if (r < 33) begin
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
        apb_if.paddr = 4'h0; apb_if.pwdata = 32'h2;
      end
    end
    @(negedge clk); #2;
    apb_idle(); wake_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
